// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, programmable wait states, word array.
// Latency: response registered WAIT+1 edges after accept; held until the initiator takes it.
// Backpressure: req_ready low in BUSY/RESP; rsp_* held stable while rsp_ready is low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (accepted only in IDLE)
//   req_we, req_sb           store / store-byte select (sb ignored for loads)
//   req_addr, req_wdata      byte address, store data (sb uses bits 7:0)
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       load data (0 for stores/errors), access rejected
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_sb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_sb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [2**ADDR_W];

  logic              w_do_access;
  logic              w_oor;
  logic              w_misal;
  logic              w_err;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;

  // Error decode works on the latched request, never on the live inputs.
  assign w_idx    = r_addr[ADDR_W+1:2];
  assign w_oor    = |(r_addr >> (ADDR_W + 2));
  // Byte stores can target any lane; everything else must be word aligned.
  assign w_misal  = !(r_we && r_sb) && (r_addr[1:0] != 2'b00);
  assign w_err    = w_oor || w_misal;
  assign w_mem_we = w_do_access && r_we && !w_err;

  // Byte store: replicate the byte onto every lane and enable only the addressed one.
  always_comb begin
    w_be     = 4'hF;
    w_wlanes = r_wdata;
    if (r_sb) begin
      w_be     = 4'b0001 << r_addr[1:0];
      w_wlanes = {4{r_wdata[7:0]}};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_do_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_do_access = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_sb      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_sb    <= req_sb;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= 4'(WAIT);
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            rsp_err   <= w_err;
            rsp_rdata <= (w_err || r_we) ? 32'd0 : r_mem[w_idx];
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Array has no reset; the write enable is derived from reset-cleared state,
  // so a reset during BUSY suppresses the write.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic        req_sb    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference memory, key = instance*65536 + word index.
  bit [31:0] mdl [int];

  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: WAIT=2, instance 1: WAIT=0, instance 2: WAIT=4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W(10),
      .WAIT  (g == 0 ? 2 : (g == 1 ? 0 : 4))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_sb   (req_sb[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  function automatic int wt(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one access with a 1024-word (4 KiB) array.
  function automatic void ref_access(input int k, input bit we, input bit sb,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic [31:0] rd, output bit err);
    int        key;
    bit [31:0] w;
    key = k * 65536 + int'(addr[11:2]);
    err = (addr >= 32'h1000) || (!(we && sb) && (addr[1:0] != 2'b00));
    rd  = 32'd0;
    if (!err) begin
      if (!we) begin
        rd = mdl[key];
      end else if (sb) begin
        w = mdl[key];
        w[8*addr[1:0] +: 8] = wdata[7:0];
        mdl[key] = w;
      end else begin
        mdl[key] = wdata;
      end
    end
  endfunction

  task automatic do_req(input int k, input bit we, input bit sb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          n;
    ref_access(k, we, sb, addr, wdata, exp_rd, exp_err);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_sb[k]    = sb;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    @(posedge clk);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      req_valid[k] = 1'b0;
      if (rsp_valid[k]) break;
      @(posedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(wt(k) + 1));
    rd = rsp_rdata[k];
    check("rsp_rdata", rsp_rdata[k], exp_rd);
    check("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
    check("post_req_ready", 32'(req_ready[k]), 32'd1);
    check("post_rdata_clr", rsp_rdata[k], 32'd0);
    check("post_err_clr", 32'(rsp_err[k]), 32'd0);
  endtask

  logic [31:0] rd;
  logic [31:0] held;
  logic [31:0] a;
  logic [31:0] keep30;
  logic [31:0] cap [3];
  int          acc [3];
  int          nacc;
  int          ncap;
  int          r;
  int          n;
  bit          we;
  bit          sb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_sb[k]    = 1'b0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
      rsp_ready[k] = 1'b0;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_req_ready", 32'(req_ready[k]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[k], 32'd0);
      check("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
    end
    rst = 1'b1;

    // Word store then load.
    do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, rd);
    check("ld_0x10", rd, 32'hDEADBEEF);

    // Byte lanes.
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h11223344, rd);
    do_req(0, 1'b1, 1'b1, 32'h22, 32'h000000AA, rd);
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, rd);
    check("lane2", rd, 32'h11AA3344);
    do_req(0, 1'b1, 1'b1, 32'h23, 32'hFFFFFF55, rd);
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, rd);
    check("lane3", rd, 32'h55AA3344);

    // Errors: out of range load, misaligned word store.
    do_req(0, 1'b0, 1'b0, 32'h4000, 32'h0, rd);
    do_req(0, 1'b1, 1'b0, 32'h21, 32'hFFFFFFFF, rd);
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, rd);
    check("err_no_write", rd, 32'h55AA3344);

    // Backpressure: hold rsp_ready low, pulse a stray request.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_sb[0] = 1'b0; req_addr[0] = 32'h20;
    @(posedge clk);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      req_valid[0] = 1'b0;
      if (rsp_valid[0]) break;
      @(posedge clk);
      n++;
    end
    check("bp_latency", 32'(n), 32'd3);
    held = rsp_rdata[0];
    check("bp_data", held, 32'h55AA3344);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_rdata_stable", rsp_rdata[0], 32'h55AA3344);
      check("bp_req_ready", 32'(req_ready[0]), 32'd0);
      if (i == 1) begin
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_sb[0] = 1'b0;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h0;
      end
      if (i == 2) req_valid[0] = 1'b0;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    check("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
    check("bp_release_ready", 32'(req_ready[0]), 32'd1);
    repeat (4) @(negedge clk);
    check("bp_no_stray_rsp", 32'(rsp_valid[0]), 32'd0);
    check("bp_idle_ready", 32'(req_ready[0]), 32'd1);
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, rd);
    check("bp_stray_ignored", rd, 32'h55AA3344);

    // Randomised traffic on a small window, with occasional out-of-range addresses.
    for (int i = 0; i < 8; i++) do_req(0, 1'b1, 1'b0, 32'h100 + 32'(4*i), $urandom, rd);
    for (int i = 0; i < 30; i++) begin
      r  = $urandom_range(0, 9);
      a  = 32'h100 + 32'($urandom_range(0, 31));
      we = (r < 5);
      sb = 1'($urandom_range(0, 1));
      if (r == 9) a = a | (32'h1000 << $urandom_range(0, 19));
      do_req(0, we, sb, a, $urandom, rd);
    end

    // WAIT=0 back-to-back loads with req_valid held and rsp_ready tied high.
    for (int i = 0; i < 3; i++) do_req(1, 1'b1, 1'b0, 32'(4*i), $urandom, rd);
    nacc = 0;
    ncap = 0;
    rsp_ready[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_sb[1]    = 1'b0;
    for (int t = 0; t < 40 && ncap < 3; t++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin
        cap[ncap] = rsp_rdata[1];
        ncap++;
      end
      if (req_ready[1]) begin
        if (nacc < 3) begin
          req_addr[1]  = 32'(4*nacc);
          req_valid[1] = 1'b1;
          acc[nacc]    = cyc + 1;
          nacc++;
        end else begin
          req_valid[1] = 1'b0;
        end
      end
    end
    req_valid[1] = 1'b0;
    check("b2b_count", 32'(ncap), 32'd3);
    if (ncap == 3) begin
      check("b2b_spacing1", 32'(acc[1] - acc[0]), 32'd3);
      check("b2b_spacing2", 32'(acc[2] - acc[1]), 32'd3);
      for (int i = 0; i < 3; i++) check("b2b_data", cap[i], mdl[65536 + i]);
    end
    repeat (2) @(negedge clk);
    rsp_ready[1] = 1'b0;

    // Reset in the middle of a WAIT=4 store.
    keep30 = $urandom;
    do_req(2, 1'b1, 1'b0, 32'h30, keep30, rd);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_sb[2] = 1'b0;
    req_addr[2] = 32'h30; req_wdata[2] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("rst_mid_busy", 32'(req_ready[2]), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_req_ready", 32'(req_ready[2]), 32'd1);
    check("arst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_no_rsp", 32'(rsp_valid[2]), 32'd0);
    do_req(2, 1'b0, 1'b0, 32'h30, 32'h0, rd);
    check("arst_mem_kept", rd, keep30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port. It accepts one load/store request at a time from the MEM-stage initiator over a valid/ready handshake and inserts a programmable number of wait states. It performs word loads, word stores and byte stores (sb) on an internal word array, then returns a response held until the initiator accepts it. It replaces the zero-latency data memory when the core is run against slower-memory timing.

## Interface

Parameters:
- ADDR_W, 10: word-address width; the array holds 2^ADDR_W 32-bit words, byte range 0 .. 2^(ADDR_W+2)-1.
- WAIT, 2: wait states per access, 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_sb  in  1  store byte; ignored when req_we=0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sb uses bits 7:0.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access rejected.

## Operation

- States: IDLE, BUSY, RESP.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
- Reset does not clear array contents.
- IDLE behaviour:
  - req_ready=1.
  - On req_valid, latch we, sb, addr and wdata, load the counter with WAIT, and go to BUSY.
- BUSY behaviour:
  - req_ready=0.
  - Each edge with counter != 0: decrement the counter.
  - Edge with counter == 0: perform the access, register rsp_rdata and rsp_err, go to RESP.
- RESP behaviour:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err stay stable until the handshake.
  - On an edge with rsp_ready=1: go to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Error conditions, checked on the latched request:
  - Out of range: addr[31:ADDR_W+2] != 0.
  - Misaligned word access (load, or store with sb=0): addr[1:0] != 0.
  - Byte stores are never misaligned.
  - On error: no array write, rsp_err=1, rsp_rdata=0.
- Load: rsp_rdata = mem[addr[ADDR_W+1:2]].
- Word store: writes the full word.
- Byte store: writes only lane addr[1:0], little-endian. Lane 0 = bits 7:0, lane 3 = bits 31:24. Other bytes are unchanged.
- Store response: rsp_rdata=0, rsp_err=0 unless rejected.
- Only one request is outstanding. No request is accepted in BUSY or RESP. req_valid in those states is ignored, not latched.

## Timing

- Request accepted on edge E0 (state IDLE, req_valid=1).
- Access and response registration happen on edge E0+WAIT+1.
- rsp_valid is high from E0+WAIT+1 until the first edge with rsp_ready=1.
- Minimum request-to-request spacing: WAIT+3 edges, with rsp_ready tied high.
- Example, WAIT=0, rsp_ready=1: accept E0, rsp_valid during cycle E1..E2, req_ready again after E2, next accept at E3.
- rsp_ready is sampled only in RESP. A high rsp_ready in IDLE or BUSY has no effect.
- rst low mid-BUSY: the access is aborted with no array write, and outputs return to reset values asynchronously.
- rst low in RESP: the response is discarded. A store already performed stays in memory.
- A load following a store to the same word sees the stored data. Read-after-write is in order because there is only one outstanding access.

## Test plan

- Word store then load, WAIT=2:
  - Store 0xDEADBEEF to 0x10: rsp_valid 3 edges after accept, rsp_err=0, rsp_rdata=0.
  - Load 0x10: rsp_rdata=0xDEADBEEF.
- Byte lanes:
  - Store word 0x11223344 at 0x20, then sb 0xAA at 0x22.
  - Load 0x20 -> 0x11AA3344.
  - sb 0x55 at 0x23, load -> 0x55AA3344.
- Errors, ADDR_W=10:
  - Load 0x4000 -> rsp_err=1, rsp_rdata=0.
  - Word store 0xFFFFFFFF to 0x21 -> rsp_err=1.
  - Load 0x20 still returns 0x55AA3344.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid: rsp_valid and rsp_rdata stay stable, req_ready stays 0.
  - Pulse req_valid in this window: the request is not latched.
  - Raise rsp_ready: IDLE on the next edge.
- WAIT=0 back-to-back with rsp_ready=1 and req_valid held high:
  - Accepts occur every 3 edges.
  - Loads of 0x0, 0x4, 0x8 return preloaded values in order.
- Reset mid-access:
  - Store 0x12345678 to 0x30 with WAIT=4; drop rst during BUSY.
  - Outputs: req_ready=1, rsp_valid=0 immediately.
  - A later load of 0x30 returns the prior contents, unchanged.
